pixel_readout: RTL and testbench
================================

# pixel_readout

Receiving end of the pixel array's read interface. While the data path holds `read` high and steps `pixel_select`, the block captures one pixel sample per cycle and buffers it in a small FIFO. It re-emits the frame as a valid/ready stream with first/last markers, decoupling the array readout from a downstream consumer that may stall. The block sits beside `pixel_array` under the sensor top level, on the same `read`/`pixel_select` nets the data path drives.

## Interface
- `pixel_count`, 4: pixels per frame.
- `data_width`, 8: bits per pixel sample.
- `fifo_depth`, 4: buffered samples; power of two, ≥2.
- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `read` input 1: read phase strobe from the data path.
- `pixel_select` input $clog2(pixel_count): index of the pixel currently being read.
- `pixel_data` input data_width: sample from the array, valid whenever `read`=1.
- `out_data` output data_width: head-of-FIFO sample.
- `out_index` output $clog2(pixel_count): pixel index of `out_data`.
- `out_first` output 1: `out_index`==0.
- `out_last` output 1: `out_index`==pixel_count-1.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: consumer accepts the sample.
- `busy` output 1: FSM is not in IDLE.
- `frame_done` output 1: one-cycle pulse at the end of a frame.
- `overflow` output 1: sticky flag; a sample was dropped during this frame.
- `seq_error` output 1: sticky flag; `pixel_select` was out of order during this frame.

## Operation
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE -> CAPTURE when `read`=1.
  - On this transition, clear `overflow`, clear `seq_error`, and set the expected index to 0.
- CAPTURE: every cycle with `read`=1 is a push of {`pixel_select`, `pixel_data`}. The expected index increments on each push and wraps from pixel_count-1 to 0.
- CAPTURE -> DRAIN when `read`=0.
- DRAIN -> IDLE when the FIFO is empty. Pulse `frame_done` for one cycle in the same cycle as this transition.
- DRAIN -> CAPTURE when `read`=1. This is a new frame:
  - Clear the flags and the expected index exactly as on IDLE -> CAPTURE.
  - The FIFO is not flushed.
  - The first cycle of `read` is still captured.
- Pop: `out_valid`=1 and `out_ready`=1.
- Push acceptance: a push is accepted if count<fifo_depth, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and `overflow` is set.
  - The dropped sample still advances the expected index.
- Count arithmetic is modulo-free. Count ranges from 0 to fifo_depth, with width $clog2(fifo_depth)+1. Read and write pointers wrap naturally.
- Sequence check: a push whose `pixel_select` differs from the expected index sets `seq_error`. The sample is still pushed.
- `out_data`, `out_index`, `out_first` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: FSM = IDLE; FIFO empty; `out_valid`=0; `busy`=0; `frame_done`=0; `overflow`=0; `seq_error`=0; `out_data`=0; `out_index`=0; `out_first`=0; `out_last`=0.
- Reset asserted mid-frame discards all buffered data immediately (asynchronous).
- Latency: a sample pushed at edge N is visible with `out_valid`=1 after edge N, i.e. 1 cycle, when the FIFO was empty.
- Throughput: one push and one pop per cycle, sustained.
- `out_valid` must not depend combinationally on `out_ready`.
- `busy` rises the cycle after the first `read`=1 edge. It falls in the same cycle as the DRAIN -> IDLE transition, together with the `frame_done` pulse.
- Flag changes are visible the cycle after the causing edge.

## Configuration
- `PIXEL_READOUT_SEQ_CHECK_EN` defined:
  - Expected-index tracking and `seq_error` are implemented as described above.
- `PIXEL_READOUT_SEQ_CHECK_EN` undefined:
  - No comparison logic is built.
  - `seq_error` is tied to 0; the port stays present.
  - All other behaviour is identical.

## Test plan
- **Basic frame:** pixel_count=4, `out_ready`=1. Hold `read` 4 cycles with `pixel_select` 0,1,2,3 and `pixel_data` 0x10,0x20,0x30,0x40.
  - Expect 4 beats 0x10..0x40, each 1 cycle after its capture.
  - Expect `out_first` on 0x10 and `out_last` on 0x40.
  - Expect one `frame_done` pulse; `overflow`=0.
- **Stalled consumer, overflow:** fifo_depth=4, `out_ready`=0, 6-cycle read of indices 0,1,2,3,0,1.
  - Expect only the first 4 samples retained and `overflow`=1.
  - Release `out_ready`: expect exactly 4 beats, then `frame_done`.
- **Full with simultaneous pop:** fill the FIFO to 4, then push and pop in the same cycle.
  - Expect the push accepted, `overflow`=0 and count unchanged at 4.
- **Out-of-order index:** `pixel_select` sequence 0,2,1,3.
  - With the macro: `seq_error`=1 from the cycle after the second push; all 4 samples delivered.
  - Without the macro: `seq_error`=0.
- **Back-to-back frame:** `read` re-asserts during DRAIN.
  - Expect the old samples delivered first, `overflow` and `seq_error` cleared, and no `frame_done` between the frames.
- **Reset mid-frame:** assert `reset` low during CAPTURE with 2 samples buffered.
  - Expect `out_valid`=0 and `busy`=0 immediately, with no clock edge required.
  - After release, a normal frame completes.

Source files
------------

// File: rtl/pixel_readout.sv
// Captures pixel samples from the array read interface into a small FIFO and
// re-emits them as a valid/ready stream. Optional macro: PIXEL_READOUT_SEQ_CHECK_EN.
module pixel_readout #(
  parameter int pixel_count = 4,
  parameter int data_width  = 8,
  parameter int fifo_depth  = 4,
  localparam int idx_w = (pixel_count > 1) ? $clog2(pixel_count) : 1,
  localparam int ptr_w = $clog2(fifo_depth),
  localparam int cnt_w = ptr_w + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic [idx_w-1:0]      pixel_select,
  input  logic [data_width-1:0] pixel_data,
  output logic [data_width-1:0] out_data,
  output logic [idx_w-1:0]      out_index,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  seq_error
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t state, next_state;

  logic [data_width-1:0] mem_data [fifo_depth];
  logic [idx_w-1:0]      mem_idx  [fifo_depth];
  logic [ptr_w-1:0]      wr_ptr, rd_ptr;
  logic [cnt_w-1:0]      count;

  logic pop, push_ok, drop, frame_start, drain_done;

  // Every read cycle is a push, including the one that starts a frame.
  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready;
  assign push_ok     = read && ((count < cnt_w'(fifo_depth)) || pop);
  assign drop        = read && !push_ok;
  assign frame_start = read && (state != CAPTURE);
  assign busy        = (state != IDLE);

  // Head fields read as zero while empty so stale entries never leak out.
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_index = out_valid ? mem_idx[rd_ptr]  : '0;
  assign out_first = out_valid && (mem_idx[rd_ptr] == '0);
  assign out_last  = out_valid && (mem_idx[rd_ptr] == idx_w'(pixel_count - 1));

  // NOTE: next-state logic assigns every output a default first, so no latch is inferred.
  always_comb begin
    next_state = state;
    drain_done = 1'b0;
    case (state)
      IDLE:    if (read) next_state = CAPTURE;
      CAPTURE: if (!read) next_state = DRAIN;
      DRAIN: begin
        if (read) begin
          next_state = CAPTURE;
        end else if (count == '0) begin
          next_state = IDLE;
          drain_done = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      frame_done <= 1'b0;
    end else begin
      state      <= next_state;
      frame_done <= drain_done;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop)     rd_ptr <= rd_ptr + ptr_w'(1);
      count <= count + cnt_w'(push_ok) - cnt_w'(pop);
    end
  end

  // NOTE: the storage array has no reset; validity comes solely from count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr] <= pixel_data;
      mem_idx[wr_ptr]  <= pixel_select;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (frame_start) begin
      overflow <= drop;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef PIXEL_READOUT_SEQ_CHECK_EN
  logic [idx_w-1:0] exp_idx, exp_cmp;
  logic             mismatch;

  // A frame-starting push is compared against index 0, not the stale tracker.
  assign exp_cmp  = frame_start ? '0 : exp_idx;
  assign mismatch = read && (pixel_select != exp_cmp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_idx   <= '0;
      seq_error <= 1'b0;
    end else begin
      if (read) begin
        exp_idx <= (exp_cmp == idx_w'(pixel_count - 1)) ? '0 : exp_cmp + idx_w'(1);
      end
      if (frame_start) begin
        seq_error <= mismatch;
      end else if (mismatch) begin
        seq_error <= 1'b1;
      end
    end
  end
`else
  assign seq_error = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: frames, overflow, full-with-pop, ordering,
// back-to-back frames and asynchronous reset mid-frame.
module tb_pixel_readout;

  localparam bit seq_en =
`ifdef PIXEL_READOUT_SEQ_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } beat_t;

  logic       clk;
  logic       reset;
  logic       read;
  logic [1:0] pixel_select;
  logic [7:0] pixel_data;
  logic [7:0] out_data;
  logic [1:0] out_index;
  logic       out_first, out_last, out_valid, out_ready;
  logic       busy, frame_done, overflow, seq_error;

  int    n_checks = 0;
  int    n_errors = 0;
  int    fd_count = 0;
  int    fd_before;
  beat_t exp_q[$];

  pixel_readout #(.pixel_count(4), .data_width(8), .fifo_depth(4)) dut (
    .clk(clk), .reset(reset), .read(read), .pixel_select(pixel_select),
    .pixel_data(pixel_data), .out_data(out_data), .out_index(out_index),
    .out_first(out_first), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done),
    .overflow(overflow), .seq_error(seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scores any beat accepted at the coming edge, then advances one cycle.
  task automatic step();
    beat_t b;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      check("beat_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        check("beat_data", out_data, b.data);
        check("beat_index", out_index, b.idx);
        check("beat_first", out_first, b.idx == 2'd0);
        check("beat_last", out_last, b.idx == 2'd3);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] idx, input logic [7:0] data, input bit accept);
    beat_t b;
    read         = 1'b1;
    pixel_select = idx;
    pixel_data   = data;
    if (accept) begin
      b.idx  = idx;
      b.data = data;
      exp_q.push_back(b);
    end
    step();
  endtask

  task automatic finish_frame();
    int n;
    read      = 1'b0;
    out_ready = 1'b1;
    step();
    n = 0;
    while (out_valid === 1'b1 && n < 32) begin
      step();
      n++;
    end
    check("drain_empty", out_valid, 0);
    check("drain_busy", busy, 1);
    check("drain_no_done_yet", frame_done, 0);
    step();
    check("frame_done_pulse", frame_done, 1);
    check("busy_falls", busy, 0);
    check("all_beats_seen", exp_q.size(), 0);
    step();
    check("frame_done_one_cycle", frame_done, 0);
  endtask

  initial begin
    reset        = 1'b0;
    read         = 1'b0;
    pixel_select = '0;
    pixel_data   = '0;
    out_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_seq_error", seq_error, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    check("rst_first", out_first, 0);
    check("rst_last", out_last, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(2'(i), 8'(8'h10 * (i + 1)), 1'b1);
      check("basic_valid", out_valid, 1);
      check("basic_latency_data", out_data, 8'h10 * (i + 1));
      check("basic_busy", busy, 1);
    end
    finish_frame();
    check("basic_overflow", overflow, 0);

    // Stalled consumer: last two samples dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push(2'(i % 4), 8'(8'hA0 + i), i < 4);
      check("stall_head_data", out_data, 8'hA0);
      check("stall_head_first", out_first, 1);
      check("stall_overflow", overflow, i >= 4);
    end
    finish_frame();
    check("stall_overflow_sticky", overflow, 1);

    // Full FIFO with a simultaneous pop accepts the push.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(2'(i), 8'(8'h50 + i), 1'b1);
    check("full_head", out_data, 8'h50);
    out_ready = 1'b1;
    push(2'd0, 8'h54, 1'b1);
    check("full_pop_overflow", overflow, 0);
    check("full_pop_head", out_data, 8'h51);
    finish_frame();

    // Out-of-order index sequence.
    out_ready = 1'b1;
    push(2'd0, 8'h60, 1'b1);
    check("ooo_seq_0", seq_error, 0);
    push(2'd2, 8'h61, 1'b1);
    check("ooo_seq_1", seq_error, seq_en);
    push(2'd1, 8'h62, 1'b1);
    check("ooo_seq_2", seq_error, seq_en);
    push(2'd3, 8'h63, 1'b1);
    check("ooo_seq_3", seq_error, seq_en);
    finish_frame();

    // Back-to-back frames: read re-asserts during DRAIN.
    out_ready = 1'b0;
    push(2'd0, 8'h70, 1'b1);
    push(2'd1, 8'h71, 1'b1);
    push(2'd3, 8'h72, 1'b1);
    push(2'd2, 8'h73, 1'b1);
    push(2'd0, 8'h74, 1'b0);
    check("b2b_a_overflow", overflow, 1);
    check("b2b_a_seq", seq_error, seq_en);
    read = 1'b0;
    step();
    check("b2b_drain_busy", busy, 1);
    out_ready = 1'b1;
    step();
    fd_before = fd_count;
    push(2'd0, 8'h80, 1'b1);
    check("b2b_b_overflow_clr", overflow, 0);
    check("b2b_b_seq_clr", seq_error, 0);
    check("b2b_b_busy", busy, 1);
    push(2'd1, 8'h81, 1'b1);
    push(2'd2, 8'h82, 1'b1);
    push(2'd3, 8'h83, 1'b1);
    check("b2b_no_done_between", fd_count, fd_before);
    finish_frame();
    check("b2b_single_done", fd_count, fd_before + 1);

    // Asynchronous reset with two samples buffered.
    out_ready = 1'b0;
    push(2'd0, 8'h90, 1'b0);
    push(2'd1, 8'h91, 1'b0);
    check("rstmid_pre_valid", out_valid, 1);
    #2;
    reset = 1'b0;
    read  = 1'b0;
    #1;
    check("rstmid_valid", out_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_data", out_data, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(2'(i), 8'(8'hB0 + i), 1'b1);
    check("rstmid_seq", seq_error, 0);
    finish_frame();
    check("rstmid_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
